// File: rtl/divmod_seq.sv
// ----------------------------------------------------------------------------
// divmod_seq -- sequential restoring divider producing quotient and remainder
//
// One quotient bit is resolved per clock, so an operation takes WIDTH cycles
// from the edge that samples start to the edge that raises done. A zero
// divisor short-circuits straight to the result state.
//
// Parameters
//   WIDTH     operand / result width in bits (4..64)
//   SIGNED    0 = unsigned operands, 1 = two's-complement operands
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   RST_N     asynchronous active-low reset
//   start     request pulse, sampled with a and b
//   a         dividend
//   b         divisor
//   busy      high while the divider is iterating
//   done      single-cycle pulse marking fresh results
//   quotient  registered quotient, held until the next done pulse
//   remainder registered remainder, held until the next done pulse
//   dbz       divide-by-zero flag, meaningful whenever done is high
// ----------------------------------------------------------------------------
module divmod_seq #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration state: dvd starts as the dividend magnitude and fills up with
    // quotient bits from the right as dividend bits leave on the left.
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic             neg_q;
    logic             neg_r;

    // Operand conditioning at the start edge
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             start_accept;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] dvd_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             last_step;

    assign a_neg  = (SIGNED != 0) && a[WIDTH-1];
    assign b_neg  = (SIGNED != 0) && b[WIDTH-1];
    // Negating the most-negative value wraps back to itself, which read as an
    // unsigned magnitude is exactly 2^(WIDTH-1), so no special case is needed.
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign b_zero = (b == '0);

    // A start seen while iterating is dropped; from IDLE or DONE it launches.
    assign start_accept = start && (state != BUSY);

    // The shifted partial remainder needs WIDTH+1 bits. If its top bit is set
    // it already exceeds any WIDTH-bit divisor, so the trial subtraction
    // cannot borrow; otherwise the sign bit of the WIDTH+1-bit difference is
    // the borrow. After a successful subtraction the result is below the
    // divisor and fits back into WIDTH bits.
    assign shifted   = {prem, dvd[WIDTH-1]};
    assign diff      = shifted - {1'b0, dsr};
    assign qbit      = shifted[WIDTH] | ~diff[WIDTH];
    assign prem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_next  = {dvd[WIDTH-2:0], qbit};

    // Truncating division: quotient sign from both operands, remainder
    // follows the dividend.
    assign q_final   = neg_q ? -dvd_next : dvd_next;
    assign r_final   = neg_r ? -prem_next : prem_next;

    assign last_step = (count == CW'(1));

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE lasts one cycle unless a new start chains
    // straight into the next operation.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = b_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = b_zero ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers. Results are only written on the edge
    // that enters DONE, so they hold between done pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count     <= '0;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (start_accept) begin
            count <= CW'(WIDTH);
            dvd   <= a_mag;
            dsr   <= b_mag;
            prem  <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (b_zero) begin
                quotient  <= '1;
                remainder <= a;
                dbz       <= 1'b1;
            end
        end else if (state == BUSY) begin
            count <= count - CW'(1);
            dvd   <= dvd_next;
            prem  <= prem_next;
            if (last_step) begin
                quotient  <= q_final;
                remainder <= r_final;
                dbz       <= 1'b0;
            end
        end
    end

endmodule
